// File: rtl/lab022_axil_pkg.sv
// rtl/lab022_axil_pkg.sv - shared constants, types and byte-merge helper for lab022_axil_regs
package lab022_axil_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = 4;

   typedef logic [1:0]            axil_resp_t;
   typedef logic [DATA_WIDTH-1:0] reg_word_t;

   localparam axil_resp_t RESP_OKAY   = 2'b00;
   localparam axil_resp_t RESP_SLVERR = 2'b10;

   function automatic reg_word_t byte_merge(input reg_word_t old_w,
                                            input reg_word_t new_w,
                                            input logic [STRB_WIDTH-1:0] strb);
      reg_word_t r;
      r = old_w;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/lab022_axil_wr_join.sv
// rtl/lab022_axil_wr_join.sv - AW/W join with held flags, commit strobe and B response handshake
module lab022_axil_wr_join
   import lab022_axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  reg_word_t             wdata_i,
   input  logic [STRB_WIDTH-1:0] wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  axil_resp_t            commit_resp_i,
   output axil_resp_t            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,
   output logic                  commit_o,
   output logic [ADDR_WIDTH-1:0] commit_addr_o,
   output reg_word_t             commit_data_o,
   output logic [STRB_WIDTH-1:0] commit_strb_o
);

   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   reg_word_t             wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   axil_resp_t            bresp_q, bresp_d;
   logic                  aw_hs, w_hs, b_hs;

   assign awready_o = !aw_held_q && !bvalid_q;
   assign wready_o  = !w_held_q && !bvalid_q;
   assign aw_hs     = awvalid_i && awready_o;
   assign w_hs      = wvalid_i && wready_o;
   assign b_hs      = bvalid_q && bready_i;
   assign bvalid_o  = bvalid_q;
   assign bresp_o   = bresp_q;

   // Held flags stay set after commit so both channels stall until the B handshake.
   assign commit_o      = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
   assign commit_addr_o = aw_held_q ? awaddr_q : awaddr_i;
   assign commit_data_o = w_held_q ? wdata_q : wdata_i;
   assign commit_strb_o = w_held_q ? wstrb_q : wstrb_i;

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = awaddr_i;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = wdata_i;
         wstrb_d  = wstrb_i;
      end
      if (commit_o) begin
         bvalid_d = 1'b1;
         bresp_d  = commit_resp_i;
      end else if (b_hs) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

endmodule

// File: rtl/lab022_axil_regs.sv
// rtl/lab022_axil_regs.sv - AXI4-Lite register file top; LAB022_AXIL_SLVERR_EN selects SLVERR for out-of-range accesses
module lab022_axil_regs
   import lab022_axil_pkg::*;
#(
   parameter int NUM_REGS   = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
   input  logic [2:0]               S_AXI_ARPROT,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]   regs_o,
   output logic [NUM_REGS-1:0]      wr_pulse_o
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   reg_word_t             regs_q [NUM_REGS];
   reg_word_t             regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic                  rvalid_q, rvalid_d;
   reg_word_t             rdata_q, rdata_d;
   axil_resp_t            rresp_q, rresp_d;

   logic                  commit;
   logic [ADDR_WIDTH-1:0] commit_addr;
   reg_word_t             commit_data;
   logic [STRB_WIDTH-1:0] commit_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  wr_in_range, rd_in_range, ar_hs;
   axil_resp_t            wr_resp, rd_resp;
   logic                  unused_bits;

   assign wr_idx      = commit_addr[ADDR_WIDTH-1:2];
   assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign wr_in_range = int'(wr_idx) < NUM_REGS;
   assign rd_in_range = int'(rd_idx) < NUM_REGS;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, commit_addr[1:0], S_AXI_ARADDR[1:0]};

`ifdef LAB022_AXIL_SLVERR_EN
   assign wr_resp = wr_in_range ? RESP_OKAY : RESP_SLVERR;
   assign rd_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
   assign wr_resp = RESP_OKAY;
   assign rd_resp = RESP_OKAY;
`endif

   lab022_axil_wr_join #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_join (
      .clk           (ACLK),
      .resetn        (ARESETN),
      .awaddr_i      (S_AXI_AWADDR),
      .awvalid_i     (S_AXI_AWVALID),
      .awready_o     (S_AXI_AWREADY),
      .wdata_i       (S_AXI_WDATA),
      .wstrb_i       (S_AXI_WSTRB),
      .wvalid_i      (S_AXI_WVALID),
      .wready_o      (S_AXI_WREADY),
      .commit_resp_i (wr_resp),
      .bresp_o       (S_AXI_BRESP),
      .bvalid_o      (S_AXI_BVALID),
      .bready_i      (S_AXI_BREADY),
      .commit_o      (commit),
      .commit_addr_o (commit_addr),
      .commit_data_o (commit_data),
      .commit_strb_o (commit_strb)
   );

   always_comb begin
      wr_pulse_d = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         if (commit && wr_in_range && wr_idx == IDX_W'(k)) begin
            regs_d[k]     = byte_merge(regs_q[k], commit_data, commit_strb);
            wr_pulse_d[k] = 1'b1;
         end
      end
   end

   // Read data comes from regs_q, so a write committing on the same edge is not yet visible.
   assign ar_hs = S_AXI_ARVALID && !rvalid_q;

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_resp;
         rdata_d  = '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) rdata_d = regs_q[k];
         end
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
         wr_pulse_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
         wr_pulse_q <= wr_pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
      assign regs_o[32*k +: 32] = regs_q[k];
   end

   assign S_AXI_ARREADY = !rvalid_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: doc/lab022_axil_regs.md
Name: lab022_axil_regs

Overview:
- AXI4-Lite slave register file; the responder end of the AXI4-Lite master VIP used in the Lab022IP bench.
- Holds NUM_REGS 32-bit software-visible registers, with byte-strobe writes and registered read data.
- Exposes the register contents and per-register write pulses to Lab022IP user logic.
- Sits inside the Lab022IP block-design wrapper, on the S00_AXI interface.

Parameters:
- NUM_REGS, 4: number of 32-bit registers; must be a power of two, 1..16.
- ADDR_WIDTH, 4: AXI address bits decoded; must be >= clog2(NUM_REGS)+2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- regs_o  out  NUM_REGS*32  register contents; reg k occupies bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after reg k is written.

Behaviour:
- Reset: synchronous; ARESETN=0 sampled at an ACLK edge clears all state.
  - Outputs in reset: all registers 0, BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse_o=0.
  - Reset mid-transaction discards any held AW/W/AR; no response is issued for it.
- Address decode: index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored. In range iff index < NUM_REGS.
- Write channel (join):
  - Held flags aw_held and w_held capture the address and data/strobe at their handshakes.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - AW and W are accepted in either order or in the same cycle.
  - Commit occurs on the first edge at which both are available (held, or handshaking that cycle).
  - At commit: byte lane i of the target register is updated iff WSTRB[i]; BVALID=1 next cycle; wr_pulse_o[index] pulses for that same cycle.
  - WSTRB=0 commits with no data change and still responds.
  - Latency: AW and W together at cycle T -> BVALID at T+1. Peak throughput is one write per 2 cycles.
  - BVALID holds, with BRESP stable, until BREADY; the held flags clear on the B handshake.
- Read channel:
  - ARREADY = !RVALID.
  - AR handshake at T -> RVALID=1 and RDATA = register[index] at T+1.
  - RDATA and RRESP stay stable until RREADY. ARREADY returns high the cycle after the R handshake.
- Simultaneous events:
  - Read of a register whose write commits on the AR-handshake edge returns the old value.
  - Read and write channels are fully independent; no ordering between them is guaranteed.
- Out-of-range access (macro off): writes are dropped, with no wr_pulse; reads return 0; response OKAY (2'b00).
- AWPROT and ARPROT are ignored.

Optional Feature:
- Macro: LAB022_AXIL_SLVERR_EN.
- Defined: an out-of-range write returns BRESP=SLVERR (2'b10) and no register changes; an out-of-range read returns RRESP=SLVERR with RDATA=0. In-range accesses are unchanged.
- Undefined: out-of-range accesses respond OKAY, as described under Behaviour.

Decomposition:
- Package lab022_axil_pkg:
  - constants DATA_WIDTH=32, STRB_WIDTH=4, RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - typedef axil_resp_t (2-bit);
  - typedef reg_word_t (32-bit);
  - function byte_merge(old, new, strb).
- Sub-module lab022_axil_wr_join: AW/W held flags, commit strobe and B handshake logic. The top level instantiates it plus the register array and the read path.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC via the VIP, then read back all four -> RDATA 0x1..0x4, RRESP=0 every time; regs_o=0x00000004_00000003_00000002_00000001.
- W presented 3 cycles before AW (0x8, data 0xDEADBEEF) -> WREADY drops after the W handshake; BVALID one cycle after the AW handshake; wr_pulse_o=4'b0100 for one cycle.
- Reg0=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> reg0 reads back 0x11BB33DD.
- BREADY and RREADY held low 10 cycles -> BVALID/RVALID and data stay stable; AWREADY/ARREADY stay low; a new AW is accepted one cycle after BREADY rises.
- NUM_REGS=2, write/read 0x8 -> macro off: OKAY, read 0, regs unchanged; macro on: BRESP=RRESP=2'b10.
- ARESETN pulsed low for one cycle with AW held and W not yet received -> no BVALID; regs_o=0; the next full write completes normally.
